// File: rtl/config_loader.sv
// -----------------------------------------------------------------------------
// config_loader
//
// Sequencer that sits directly in front of the configuration latch bank. It
// takes configuration words from a valid/ready stream and writes them, one
// word per slot, into a bank of level-sensitive latches via a shared data bus
// and one-hot latch enables.
//
// Every word goes through four cycles: accept (LOAD), setup (SETUP), enable
// pulse (STROBE) and hold (HOLD). The data bus is therefore stable for a full
// cycle on both sides of each enable pulse, so the latches capture cleanly.
//
// Ports
//   clk            rising-edge clock for all logic
//   reset          synchronous, active-low reset (0 = reset)
//   io_start       begin a full load; only honoured in IDLE or DONE
//   io_abort       return to IDLE from any state (wins over io_start)
//   io_in_valid    upstream word valid
//   io_in_ready    loader can accept a word this cycle
//   io_in_bits     upstream configuration word
//   io_d_in        registered latch data bus
//   io_configs_en  registered one-hot latch enables, one bit per slot
//   io_word_idx    index of the slot currently being loaded
//   io_busy        a sequence is in progress (not IDLE and not DONE)
//   io_done        all slots written; held until start, abort or reset
// -----------------------------------------------------------------------------
module config_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 17,
    parameter int IDX_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  io_start,
    input  logic                  io_abort,
    input  logic                  io_in_valid,
    output logic                  io_in_ready,
    input  logic [DATA_WIDTH-1:0] io_in_bits,
    output logic [DATA_WIDTH-1:0] io_d_in,
    output logic [NUM_WORDS-1:0]  io_configs_en,
    output logic [IDX_WIDTH-1:0]  io_word_idx,
    output logic                  io_busy,
    output logic                  io_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETUP  = 3'd2,
        S_STROBE = 3'd3,
        S_HOLD   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);

    state_t                 state_reg, state_next;
    logic [DATA_WIDTH-1:0]  d_in_reg,  d_in_next;
    logic [NUM_WORDS-1:0]   en_reg,    en_next;
    logic [IDX_WIDTH-1:0]   idx_reg,   idx_next;
    logic                   done_reg,  done_next;

    logic                   in_ready;
    logic                   accept;
    logic                   last_slot;
    logic [NUM_WORDS-1:0]   slot_onehot;

    // Decode the current slot index into a one-hot enable pattern. Indices
    // beyond NUM_WORDS-1 never occur because the index stops at LAST_IDX.
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_slot_decode
            assign slot_onehot[gi] = (idx_reg == IDX_WIDTH'(gi));
        end
    endgenerate

    assign last_slot = (idx_reg == LAST_IDX);

    // Ready is withdrawn during an abort so that a word is never handshaken
    // in a cycle whose data is about to be dropped.
    assign in_ready = (state_reg == S_LOAD) && !io_abort;
    assign accept   = in_ready && io_in_valid;

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        d_in_next  = d_in_reg;
        idx_next   = idx_reg;
        done_next  = done_reg;
        en_next    = '0;

        if (io_abort) begin
            // Data bus is deliberately retained: the latches may still be
            // transparent for the slot that was strobing when abort arrived.
            state_next = S_IDLE;
            idx_next   = '0;
            done_next  = 1'b0;
        end else begin
            unique case (state_reg)
                S_IDLE, S_DONE: begin
                    if (io_start) begin
                        state_next = S_LOAD;
                        idx_next   = '0;
                        done_next  = 1'b0;
                    end
                end

                S_LOAD: begin
                    if (accept) begin
                        d_in_next  = io_in_bits;
                        state_next = S_SETUP;
                    end
                end

                S_SETUP: begin
                    // Enables are registered, so the pulse is scheduled here
                    // and appears on the outputs during STROBE.
                    state_next = S_STROBE;
                    en_next    = slot_onehot;
                end

                S_STROBE: begin
                    state_next = S_HOLD;
                end

                S_HOLD: begin
                    if (last_slot) begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = S_LOAD;
                        idx_next   = idx_reg + IDX_WIDTH'(1);
                    end
                end

                default: begin
                    state_next = S_IDLE;
                    idx_next   = '0;
                    done_next  = 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            d_in_reg  <= '0;
            en_reg    <= '0;
            idx_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            d_in_reg  <= d_in_next;
            en_reg    <= en_next;
            idx_reg   <= idx_next;
            done_reg  <= done_next;
        end
    end

    assign io_in_ready   = in_ready;
    assign io_d_in       = d_in_reg;
    assign io_configs_en = en_reg;
    assign io_word_idx   = idx_reg;
    assign io_done       = done_reg;
    assign io_busy       = (state_reg != S_IDLE) && (state_reg != S_DONE);

endmodule

// File: tb/tb_config_loader.sv
// -----------------------------------------------------------------------------
// tb_config_loader
//
// Directed testbench for config_loader. Cycle c of a load sequence is the
// c-th clock period after io_start is presented (c = 0). Expected values are
// hand-derived: word k is accepted in cycle 1+4k, strobed in cycle 3+4k and
// io_done rises in cycle 69 for 17 words.
// -----------------------------------------------------------------------------
module tb_config_loader;

    localparam int DW = 32;
    localparam int NW = 17;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          io_start = 1'b0;
    logic          io_abort = 1'b0;
    logic          io_in_valid = 1'b0;
    logic          io_in_ready;
    logic [DW-1:0] io_in_bits = '0;
    logic [DW-1:0] io_d_in;
    logic [NW-1:0] io_configs_en;
    logic [IW-1:0] io_word_idx;
    logic          io_busy;
    logic          io_done;

    int n_checks = 0;
    int n_bad    = 0;

    config_loader #(
        .DATA_WIDTH (DW),
        .NUM_WORDS  (NW),
        .IDX_WIDTH  (IW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .io_start      (io_start),
        .io_abort      (io_abort),
        .io_in_valid   (io_in_valid),
        .io_in_ready   (io_in_ready),
        .io_in_bits    (io_in_bits),
        .io_d_in       (io_d_in),
        .io_configs_en (io_configs_en),
        .io_word_idx   (io_word_idx),
        .io_busy       (io_busy),
        .io_done       (io_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " d_in"},  64'(io_d_in),       64'd0);
        check({tag, " en"},    64'(io_configs_en), 64'd0);
        check({tag, " idx"},   64'(io_word_idx),   64'd0);
        check({tag, " busy"},  64'(io_busy),       64'd0);
        check({tag, " done"},  64'(io_done),       64'd0);
        check({tag, " ready"}, 64'(io_in_ready),   64'd0);
    endtask

    // Expected outputs in cycle c of an uninterrupted sequence.
    task automatic check_cycle(input int c, input logic [DW-1:0] base, input logic [DW-1:0] prev);
        int            k;
        int            p;
        logic [NW-1:0] e_en;
        logic [DW-1:0] e_d;
        string         t;
        t = $sformatf("c%0d", c);
        check({t, " onehot"}, 64'($countones(io_configs_en) <= 1), 64'd1);
        if (c == 0) begin
            check({t, " busy"},  64'(io_busy),       64'd0);
            check({t, " en"},    64'(io_configs_en), 64'd0);
            check({t, " ready"}, 64'(io_in_ready),   64'd0);
        end else if (c <= 4 * NW) begin
            k    = (c - 1) / 4;
            p    = (c - 1) % 4;
            e_en = (p == 2) ? (NW'(1) << k) : '0;
            if (p == 0) e_d = (k == 0) ? prev : base + DW'(k - 1);
            else        e_d = base + DW'(k);
            check({t, " busy"},  64'(io_busy),       64'd1);
            check({t, " done"},  64'(io_done),       64'd0);
            check({t, " idx"},   64'(io_word_idx),   64'(k));
            check({t, " ready"}, 64'(io_in_ready),   64'(p == 0));
            check({t, " d_in"},  64'(io_d_in),       64'(e_d));
            check({t, " en"},    64'(io_configs_en), 64'(e_en));
            if (p == 2) $display("slot %0d strobed with data %h", k, io_d_in);
        end else begin
            check({t, " busy"},  64'(io_busy),       64'd0);
            check({t, " done"},  64'(io_done),       64'd1);
            check({t, " idx"},   64'(io_word_idx),   64'(NW - 1));
            check({t, " ready"}, 64'(io_in_ready),   64'd0);
            check({t, " d_in"},  64'(io_d_in),       64'(base + DW'(NW - 1)));
            check({t, " en"},    64'(io_configs_en), 64'd0);
        end
    endtask

    // Present the correct word in LOAD cycles and junk everywhere else, so a
    // word wrongly consumed outside LOAD shows up on io_d_in.
    task automatic drive_bits(input int c, input logic [DW-1:0] base);
        if (c >= 1 && c <= 4 * NW && ((c - 1) % 4) == 0)
            io_in_bits = base + DW'((c - 1) / 4);
        else
            io_in_bits = 32'hDEAD_0000 | DW'(c);
    endtask

    // Run a load sequence with io_in_valid high; optionally stall before
    // word 3 and optionally stop (without clocking) at cycle stop_at.
    task automatic run_load(input logic [DW-1:0] base, input logic [DW-1:0] prev,
                            input int stall_len, input int stop_at);
        for (int c = 0; c <= 4 * NW + 2; c++) begin
            if (c == 13) begin
                for (int s = 0; s < stall_len; s++) begin
                    io_start    = 1'b0;
                    io_in_valid = 1'b0;
                    io_in_bits  = 32'hDEAD_BEEF;
                    check($sformatf("stall%0d ready", s), 64'(io_in_ready),   64'd1);
                    check($sformatf("stall%0d en", s),    64'(io_configs_en), 64'd0);
                    check($sformatf("stall%0d d_in", s),  64'(io_d_in),       64'(base + DW'(2)));
                    check($sformatf("stall%0d idx", s),   64'(io_word_idx),   64'd3);
                    tick();
                end
            end
            io_in_valid = 1'b1;
            // Pulses at 10 and 30 land while busy and must be ignored.
            io_start    = (c == 0) || (c == 10) || (c == 30);
            drive_bits(c, base);
            check_cycle(c, base, prev);
            if (c == stop_at) begin
                io_start = 1'b0;
                return;
            end
            tick();
        end
        io_start = 1'b0;
    endtask

    initial begin
        // Reset held for three cycles with valid high.
        reset       = 1'b0;
        io_in_valid = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b1;

        $display("full load base a5a50000");
        run_load(32'hA5A5_0000, 32'h0, 0, -1);

        $display("full load with 5-cycle stall before word 3");
        run_load(32'h5A5A_0000, 32'hA5A5_0010, 5, -1);

        $display("load aborted in strobe of word 7");
        run_load(32'h3C3C_0000, 32'h5A5A_0010, 0, 31);
        io_abort = 1'b1;
        tick();
        io_abort = 1'b0;
        check("abort en",    64'(io_configs_en), 64'd0);
        check("abort idx",   64'(io_word_idx),   64'd0);
        check("abort busy",  64'(io_busy),       64'd0);
        check("abort done",  64'(io_done),       64'd0);
        check("abort ready", 64'(io_in_ready),   64'd0);
        check("abort d_in",  64'(io_d_in),       64'(32'h3C3C_0007));
        tick();
        check("abort+2 en",  64'(io_configs_en), 64'd0);
        check("abort+2 busy", 64'(io_busy),      64'd0);

        $display("reload from slot 0, reset in hold of word 10");
        run_load(32'hC3C3_0000, 32'h3C3C_0007, 0, 44);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_all_zero("midreset");

        $display("full load after reset");
        run_load(32'h9696_0000, 32'h0, 0, -1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    // Safety net so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Sequencer directly upstream of the configuration latch bank.
- Accepts configuration words over a valid/ready stream and drives the bank's shared data bus plus one-hot latch enables, one slot per word.
- Guarantees data is stable for a full cycle before and after every enable pulse, so the level-sensitive latches capture cleanly.
- Reports busy/done to the tile's configuration controller.

Parameters:
- DATA_WIDTH, 32, width of each configuration word and of the latch data bus.
- NUM_WORDS, 17, number of latch slots, which is also the width of the enable vector.
- IDX_WIDTH, 5, width of the word index; must be at least clog2(NUM_WORDS).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset; 0 = reset.
- io_start  input  1  begin a full load sequence; sampled only in IDLE or DONE.
- io_abort  input  1  terminate any sequence and return to IDLE.
- io_in_valid  input  1  upstream word valid.
- io_in_ready  output  1  loader can accept a word.
- io_in_bits  input  DATA_WIDTH  upstream configuration word.
- io_d_in  output  DATA_WIDTH  latch data bus; registered.
- io_configs_en  output  NUM_WORDS  one-hot latch enables; registered.
- io_word_idx  output  IDX_WIDTH  index of the slot currently being loaded.
- io_busy  output  1  sequence in progress (any state other than IDLE or DONE).
- io_done  output  1  all NUM_WORDS slots written; held until the next start, abort or reset.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE.
  - io_d_in, io_configs_en, io_word_idx, io_busy, io_done, io_in_ready all 0.
  - Reset mid-sequence discards progress; no enable pulse may appear in the cycle after reset.
- States: IDLE, LOAD, SETUP, STROBE, HOLD, DONE.
- IDLE / DONE:
  - io_in_ready=0 and io_configs_en=0.
  - io_start=1 moves to LOAD, sets idx=0 and clears io_done.
- LOAD:
  - io_in_ready=1.
  - On io_in_valid&&io_in_ready: io_d_in<=io_in_bits and go to SETUP.
  - Otherwise stay in LOAD, with io_d_in unchanged.
- SETUP:
  - io_in_ready=0 and io_configs_en=0; io_d_in stable.
  - Always go to STROBE.
- STROBE:
  - io_configs_en has bit idx set and all other bits 0, for exactly one cycle.
  - io_d_in is unchanged.
- HOLD:
  - io_configs_en=0; io_d_in unchanged.
  - If idx==NUM_WORDS-1: go to DONE and set io_done=1.
  - Otherwise increment idx and go to LOAD.
- io_d_in changes only on a LOAD accept, never while any enable bit is high or in the cycle after one.
- Latency:
  - 4 cycles per word (accept, setup, strobe, hold) when io_in_valid is held high.
  - A full load is 4*NUM_WORDS cycles from the first LOAD cycle to DONE.
- io_start is ignored while busy. io_start together with io_abort: abort wins.
- io_abort=1 in any state:
  - Next state is IDLE; io_configs_en=0, io_done=0 and idx=0 next cycle.
  - io_d_in is retained.
  - An abort during STROBE ends the pulse next cycle; that slot may have been written.
- io_in_valid outside LOAD is ignored; no word is consumed.
- io_word_idx is updated only at the HOLD->LOAD transition and on start, abort or reset, so it never wraps.
- At most one bit of io_configs_en is high in any cycle, and never during reset.

Test Plan:
- Reset, then hold for 3 cycles -> all outputs 0 and state IDLE; io_in_ready=0 even with io_in_valid=1.
- Start at cycle 0 with io_in_valid=1 continuously, word k = 0xA5A50000+k ->
  - Word k is accepted in cycle 1+4k.
  - io_configs_en=1<<k in cycle 3+4k, with io_d_in=0xA5A50000+k stable from cycle 2+4k to 4+4k.
  - io_done=1 from cycle 69.
- Stall: drop io_in_valid for 5 cycles before word 3 -> the loader waits in LOAD with io_in_ready=1, no enable activity and io_d_in=word 2; the sequence then resumes with en[3].
- Abort during the STROBE of word 7 -> en[7] lasts one cycle, the next cycle is IDLE with en=0 and idx=0; a new start reloads from slot 0.
- io_start pulsed mid-sequence and io_in_valid pulsed in SETUP/HOLD -> no effect, and the sequence and word count are unchanged.
- Reset asserted during HOLD of word 10 -> all outputs 0 next cycle; a subsequent start completes all 17 slots, with a one-hot check on every cycle.
